// File: rtl/dec_scan_seq.sv
// dec_scan_seq: address scanner for a 4x16 decoder.
// A start request in IDLE steps the address 0..LAST, holding each value for
// DWELL cycles, then emits a one-cycle done pulse. hold freezes progress and
// stop aborts without a done pulse.
// Optional build macro DEC_SCAN_LOOP_EN: end of scan wraps to address 0 and
// keeps scanning, pulsing done alongside the wrapped address.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | decoder disabled, address 0, waiting for start
// SCAN  | decoder enabled, address held for DWELL cycles per step
// DONE  | one-cycle completion pulse, decoder disabled
module dec_scan_seq #(
    parameter int unsigned DWELL = 5,
    parameter int unsigned LAST  = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic hold,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic en_n,
    output logic busy,
    output logic done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] DWELL_TC = 8'(DWELL - 1);
    localparam logic [3:0] LAST_A   = 4'(LAST);

    logic [1:0] state;
    logic [3:0] addr;
    logic [7:0] cnt;

    // addr is a register, so the decoder address lines are registered outputs
    assign {a, b, c, d} = addr;

    // Sequencer: state, address, dwell counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= 4'd0;
            cnt   <= 8'd0;
            en_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // stop takes priority over a simultaneous start
                    if (start && !stop) begin
                        state <= SCAN;
                        addr  <= 4'd0;
                        cnt   <= 8'd0;
                        en_n  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        // abort beats both hold and end-of-scan
                        state <= IDLE;
                        addr  <= 4'd0;
                        cnt   <= 8'd0;
                        en_n  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (!hold) begin
                        if (cnt == DWELL_TC) begin
                            cnt <= 8'd0;
                            if (addr == LAST_A) begin
                                addr <= 4'd0;
                                done <= 1'b1;
`ifdef DEC_SCAN_LOOP_EN
                                // wrap and keep the decoder enabled
                                state <= SCAN;
`else
                                state <= DONE;
                                en_n  <= 1'b1;
                                busy  <= 1'b0;
`endif
                            end else begin
                                addr <= addr + 4'd1;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    addr  <= 4'd0;
                    cnt   <= 8'd0;
                    en_n  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    addr  <= 4'd0;
                    cnt   <= 8'd0;
                    en_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Testbench for dec_scan_seq: two instances (DWELL=5/LAST=15 and
// DWELL=1/LAST=3) share stimulus and are compared every cycle against a
// scan-position reference model, plus directed timing checks.
module tb_dec_scan_seq;

    logic clk = 1'b0;
    logic rst, start, stop, hold;
    logic a1, b1, c1, d1, en_n1, busy1, done1;
    logic a2, b2, c2, d2, en_n2, busy2, done2;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef DEC_SCAN_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int DW [2] = '{5, 1};
    localparam int LS [2] = '{15, 3};
    localparam logic [6:0] IDLE_V = 7'b0000100;

    // model: mode 0 idle, 1 scanning, 2 done pulse; p = unheld scan cycles so far
    int mode [2];
    int p    [2];
    bit dflag[2];

    dec_scan_seq #(.DWELL(5), .LAST(15)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
        .a(a1), .b(b1), .c(c1), .d(d1), .en_n(en_n1), .busy(busy1), .done(done1)
    );

    dec_scan_seq #(.DWELL(1), .LAST(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
        .a(a2), .b(b2), .c(c2), .d(d2), .en_n(en_n2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs(input int i);
        if (i == 0) return {a1, b1, c1, d1, en_n1, busy1, done1};
        return {a2, b2, c2, d2, en_n2, busy2, done2};
    endfunction

    function automatic logic [6:0] expv(input int i);
        logic [3:0] ad;
        if (mode[i] == 1) begin
            ad = 4'(p[i] / DW[i]);
            return {ad, 1'b0, 1'b1, dflag[i]};
        end
        if (mode[i] == 2) return 7'b0000101;
        return IDLE_V;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; p[i] = 0; dflag[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic st, input logic sp, input logic hd);
        for (int i = 0; i < 2; i++) begin
            dflag[i] = 1'b0;
            case (mode[i])
                0: if (st && !sp) begin mode[i] = 1; p[i] = 0; end
                1: begin
                    if (sp) mode[i] = 0;
                    else if (!hd) begin
                        p[i]++;
                        if (p[i] == (LS[i] + 1) * DW[i]) begin
                            if (LOOP) begin p[i] = 0; dflag[i] = 1'b1; end
                            else mode[i] = 2;
                        end
                    end
                end
                default: mode[i] = 0;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // drive inputs for one cycle, advance model at the edge, check at negedge
    task automatic cycle(input logic st, input logic sp, input logic hd);
        start = st; stop = sp; hold = hd;
        @(posedge clk);
        model_step(st, sp, hd);
        @(negedge clk);
        chk("model_d5", obs(0), expv(0));
        chk("model_d1", obs(1), expv(1));
    endtask

    initial begin
        int t1, t2, cyc;
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        model_reset();
        #2;
        chk("reset_d5", obs(0), IDLE_V);
        chk("reset_d1", obs(1), IDLE_V);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0);

        // full scan latency, start at cycle 0
        t1 = -1; t2 = -1;
        cycle(1, 0, 0);
        cyc = 1;
        for (int k = 0; k < 100; k++) begin
            if (done1 === 1'b1 && t1 < 0) t1 = cyc;
            if (done2 === 1'b1 && t2 < 0) t2 = cyc;
            cycle(0, 0, 0);
            cyc++;
        end
        chk_int("latency_d5", t1, 81);
        chk_int("latency_d1", t2, 5);

        // hold high during cycles 3..6
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle(0, 0, (k >= 3 && k <= 6));
            if (k == 8) chk("hold_addr_c9", {a1, b1, c1, d1, en_n1, busy1, done1}, 7'b0000010);
            if (k == 9) chk("hold_addr_c10", {a1, b1, c1, d1, en_n1, busy1, done1}, 7'b0001010);
        end

        // stop during cycle 12
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle(0, (k == 12), 0);
        end
        chk("stop_c13", obs(0), IDLE_V);
        t1 = 0;
        for (int k = 0; k < 90; k++) begin
            cycle(0, 0, 0);
            if (done1 === 1'b1) t1++;
        end
        chk_int("stop_no_done", t1, 0);

        // start and stop together in IDLE
        cycle(1, 1, 0);
        chk("start_stop_idle", obs(0), IDLE_V);
        cycle(0, 0, 0);

        // async reset in the middle of cycle 20 of a scan
        cycle(1, 0, 0);
        for (int k = 1; k < 20; k++) cycle(0, 0, 0);
        start = 1'b0; stop = 1'b0; hold = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_d5", obs(0), IDLE_V);
        chk("async_rst_d1", obs(1), IDLE_V);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) cycle(0, 0, 0);
        chk("post_rst_idle", obs(0), IDLE_V);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 8) == 0, ($urandom % 150) == 0, ($urandom % 6) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_scan_seq.md
DEC_SCAN_SEQ -- requirements
Module: dec_scan_seq

Interface
REQ-001 The block SHALL have parameter DWELL, default 5, giving clock cycles each address is held (legal 1..255).
REQ-002 The block SHALL have parameter LAST, default 15, giving the final address of a scan (legal 0..15).
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  request to begin a scan; sampled only in IDLE.
REQ-006 Port stop  input  1  abort request; sampled in SCAN and IDLE.
REQ-007 Port hold  input  1  freezes scan progress while high.
REQ-008 Ports a, b, c, d  output  1 each  4-bit address to the 4x16 decoder, a = MSB, d = LSB.
REQ-009 Port en_n  output  1  decoder enable, active-low; 0 only while scanning.
REQ-010 Port busy  output  1  high while in SCAN.
REQ-011 Port done  output  1  single-cycle completion pulse.

Function
REQ-012 The block SHALL implement states IDLE, SCAN, DONE; all outputs SHALL be registered.
REQ-013 In IDLE, outputs SHALL be abcd=0000, en_n=1, busy=0, done=0.
REQ-014 IDLE with start=1 and stop=0 SHALL enter SCAN next cycle with address 0, dwell counter 0.
REQ-015 IDLE with start=1 and stop=1 in the same cycle SHALL remain IDLE (stop wins).
REQ-016 In SCAN, en_n=0 and busy=1; the 8-bit dwell counter SHALL increment each cycle hold=0.
REQ-017 When the dwell counter equals DWELL-1 and address is below LAST, the counter SHALL clear and the address SHALL increment by 1 next cycle.
REQ-018 When the dwell counter equals DWELL-1 and address equals LAST, the block SHALL enter DONE next cycle.
REQ-019 hold=1 in SCAN SHALL freeze counter and address; en_n stays 0, busy stays 1.
REQ-020 stop=1 in SCAN SHALL enter IDLE next cycle with IDLE outputs and no done pulse; stop overrides hold and end-of-scan.
REQ-021 start in SCAN or DONE SHALL be ignored.
REQ-022 DONE SHALL last exactly one cycle with done=1, en_n=1, busy=0, abcd=0000, then go to IDLE.
REQ-023 Each address value SHALL be presented for exactly DWELL cycles absent hold; scan latency from start to done = (LAST+1)*DWELL+1 cycles.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force IDLE, address 0, counter 0, abcd=0000, en_n=1, busy=0, done=0.
REQ-025 rst asserted mid-scan SHALL abort the scan with no done pulse; after release a new start is required.

Configuration
REQ-026 Macro DEC_SCAN_LOOP_EN, when defined, SHALL make end of scan wrap address LAST to 0 and stay in SCAN (en_n=0, busy=1), pulsing done=1 for one cycle concurrent with address 0; only stop or rst end scanning.
REQ-027 Without DEC_SCAN_LOOP_EN, end of scan SHALL follow REQ-018/REQ-022 (one-shot).

Verification
REQ-028 DWELL=5, LAST=15, start pulse at cycle 0 -> address k on cycles 1+5k..5+5k, address 15 on cycles 76-80, done=1 only at cycle 81, IDLE at 82.
REQ-029 DWELL=1, LAST=3, start at cycle 0 -> abcd 0000,0001,0010,0011 on cycles 1-4, done at cycle 5, en_n=0 only cycles 1-4.
REQ-030 DWELL=5, hold high cycles 3-6 after start at 0 -> address 0 held cycles 1-9, address 1 from cycle 10.
REQ-031 stop at cycle 12 of a scan -> cycle 13 abcd=0000, en_n=1, busy=0; done never asserted.
REQ-032 rst asserted mid-cycle at cycle 20 -> outputs at reset values before next edge; start and stop together in IDLE -> remains IDLE.
REQ-033 With DEC_SCAN_LOOP_EN, DWELL=5, LAST=15 -> done=1 at cycle 81 with abcd=0000, en_n=0; second done at cycle 161; stop ends scan.
